// File: rtl/mmio_controller.sv
`default_nettype none
// ============================================================================
// Module   : mmio_controller
// Purpose  : Memory-mapped I/O target that sits beside DMEM/BIOS in the
//            RISC-V datapath. It buffers UART RX bytes in a small FIFO, holds
//            one pending UART TX byte, and keeps free-running cycle and
//            retired-instruction counters. Load data has one cycle of
//            latency, matching DMEM/BIOS.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             system clock; all state changes on the rising edge
//   rst_n           asynchronous active-low reset
//   rd_en_i         load to the I/O region this cycle
//   rd_addr_i[31:0] load byte address (bits [1:0] ignored)
//   rd_data_o[31:0] registered load data, valid the cycle after rd_en_i
//   wr_en_i         store to the I/O region this cycle
//   wr_addr_i[31:0] store byte address (bits [1:0] ignored)
//   wr_data_i[31:0] lane-aligned store data
//   wr_mask_i[3:0]  byte write mask
//   inst_retire_i   one instruction commits this cycle
//   rx_data_i[7:0]  byte from UART receiver
//   rx_valid_i      rx_data_i valid
//   rx_ready_o      RX FIFO can accept a byte (not full)
//   tx_data_o[7:0]  byte to UART transmitter
//   tx_valid_o      tx_data_o pending
//   tx_ready_i      transmitter accepts tx_data_o
// Register map (word offset = addr[7:2], selected when addr[31:28]==IO_NIBBLE)
//   0x00 R UART_CTRL {30'b0, rx_nonempty, tx_free}
//   0x04 R UART_RX   {24'b0, FIFO head}, pops when nonempty
//   0x08 W UART_TX   wr_data[7:0] when wr_mask[0]
//   0x10 R CYCLE_CNT
//   0x14 R INST_CNT
//   0x18 W CNT_RST   clears both counters when any mask bit is set
// ============================================================================
module mmio_controller #(
    parameter int         RX_DEPTH  = 8,
    parameter logic [3:0] IO_NIBBLE = 4'h8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en_i,
    input  logic [31:0] rd_addr_i,
    output logic [31:0] rd_data_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_mask_i,
    input  logic        inst_retire_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);

    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] c_off_uart_ctrl = 6'h00;
    localparam logic [5:0] c_off_uart_rx   = 6'h01;
    localparam logic [5:0] c_off_uart_tx   = 6'h02;
    localparam logic [5:0] c_off_cycle_cnt = 6'h04;
    localparam logic [5:0] c_off_inst_cnt  = 6'h05;
    localparam logic [5:0] c_off_cnt_rst   = 6'h06;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_rd_hit;
    logic       w_wr_hit;
    logic [5:0] w_rd_off;
    logic [5:0] w_wr_off;

    assign w_rd_hit = rd_en_i && (rd_addr_i[31:28] == IO_NIBBLE);
    assign w_wr_hit = wr_en_i && (wr_addr_i[31:28] == IO_NIBBLE);
    assign w_rd_off = rd_addr_i[7:2];
    assign w_wr_off = wr_addr_i[7:2];

    // Address bits outside the decode and the upper store lanes are
    // intentionally don't-care; the register map aliases across addr[27:8].
    logic w_unused;
    assign w_unused = &{1'b0, rd_addr_i[27:8], rd_addr_i[1:0],
                        wr_addr_i[27:8], wr_addr_i[1:0], wr_data_i[31:8]};

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem_q [RX_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_push;
    logic             w_pop;

    assign w_fifo_empty = (count_q == '0);
    assign w_fifo_full  = (count_q == CNT_W'(RX_DEPTH));
    assign rx_ready_o   = !w_fifo_full;
    assign w_push       = rx_valid_i && !w_fifo_full;
    // An empty UART_RX read returns zero and leaves the pointers alone.
    assign w_pop        = w_rd_hit && (w_rd_off == c_off_uart_rx) && !w_fifo_empty;

    // Storage carries no reset: stale entries are never visible because
    // the head is only read while the count is nonzero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX holding register
    // ------------------------------------------------------------------
    tx_state_t  tx_state_q;
    tx_state_t  tx_state_d;
    logic [7:0] tx_data_q;
    logic [7:0] tx_data_d;
    logic       w_tx_write;

    assign w_tx_write = w_wr_hit && (w_wr_off == c_off_uart_tx) && wr_mask_i[0];

    // A store that arrives while a byte is pending is dropped, even if the
    // transmitter accepts the pending byte in the same cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (w_tx_write) begin
                    tx_data_d  = wr_data_i[7:0];
                    tx_state_d = TX_PEND;
                end
            end
            TX_PEND: begin
                if (tx_ready_i) begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_valid_o = (tx_state_q == TX_PEND);
    assign tx_data_o  = tx_data_q;

    // ------------------------------------------------------------------
    // Cycle and retired-instruction counters
    // ------------------------------------------------------------------
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] inst_cnt_q;
    logic [31:0] inst_cnt_d;
    logic        w_cnt_clr;

    assign w_cnt_clr = w_wr_hit && (w_wr_off == c_off_cnt_rst) && (|wr_mask_i);

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        inst_cnt_d  = inst_cnt_q + {31'd0, inst_retire_i};
        if (w_cnt_clr) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Load data path: counters report their value before this edge's update
    // ------------------------------------------------------------------
    logic [31:0] w_rd_value;
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    always_comb begin
        w_rd_value = '0;
        if (w_rd_hit) begin
            case (w_rd_off)
                c_off_uart_ctrl: w_rd_value = {30'd0, !w_fifo_empty, !tx_valid_o};
                c_off_uart_rx:   w_rd_value = w_fifo_empty ? 32'd0
                                                           : {24'd0, fifo_mem_q[rd_ptr_q]};
                c_off_cycle_cnt: w_rd_value = cycle_cnt_q;
                c_off_inst_cnt:  w_rd_value = inst_cnt_q;
                default:         w_rd_value = '0;
            endcase
        end
    end

    assign rd_data_d = rd_en_i ? w_rd_value : rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire
